// File: rtl/imem_pkg.sv
// Shared widths and arbiter state encoding for the instruction-memory arbiter.
package imem_pkg;
  localparam int IMEM_AW = 10;
  localparam int IMEM_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD
  } arb_state_t;
endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of cycles the loader has waited; o_force flags that the
// loader must win the next arbitration.
module imem_starve_ctr #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  input  logic i_clr,
  output logic o_force
);
  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] r_cnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == CNT_MAX) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_wait)
      r_cnt <= sat_inc(r_cnt);
  end

  assign o_force = (r_cnt == CNT_MAX);
endmodule

// File: rtl/imem_arb.sv
// Single-port imem arbiter between the fetch stage (reads) and the loader
// (write bursts). Optional perf counters under macro IMEM_ARB_PERF_EN.
module imem_arb
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic [IMEM_AW-1:0] f_addr,
  input  logic               halting,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [IMEM_DW-1:0] f_rdata,
  output logic               stall,
  input  logic               ld_valid,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [IMEM_DW-1:0] ld_wdata,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               mem_en,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [IMEM_DW-1:0] mem_wdata,
  input  logic [IMEM_DW-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_load,
  output logic [31:0]        perf_starve
`endif
);
  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_f_rvalid;
  logic       w_force;

  imem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .i_wait (ld_valid && !ld_ready),
    .i_clr  (ld_ready),
    .o_force(w_force)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_f_rvalid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_f_rvalid <= f_gnt;
    end
  end

  // Grants are suppressed while rst is high so a burst cut by reset never
  // writes a partial beat.
  always_comb begin
    w_next   = r_state;
    f_gnt    = 1'b0;
    ld_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE, FETCH: begin
          if (ld_valid && (halting || !f_req || w_force)) begin
            ld_ready = 1'b1;
            w_next   = LOAD;
          end else if (f_req && !halting) begin
            f_gnt  = 1'b1;
            w_next = FETCH;
          end else begin
            w_next = IDLE;
          end
        end
        LOAD: begin
          ld_ready = ld_valid;
          if (!ld_valid || ld_last)
            w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign mem_en    = f_gnt | ld_ready;
  assign mem_we    = ld_ready;
  assign mem_addr  = ld_ready ? ld_addr : f_addr;
  assign mem_wdata = ld_wdata;
  assign f_rvalid  = r_f_rvalid;
  assign f_rdata   = mem_rdata;
  assign stall     = f_req && !f_gnt && !halting;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_load;
  logic [31:0] r_perf_starve;
  logic        w_force_gnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // A loader grant out of arbitration while fetch was eligible can only be a forced one.
  assign w_force_gnt = ld_ready && (r_state != LOAD) && f_req && !halting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch  <= '0;
      r_perf_load   <= '0;
      r_perf_starve <= '0;
    end else begin
      if (f_gnt)       r_perf_fetch  <= sat_inc32(r_perf_fetch);
      if (ld_ready)    r_perf_load   <= sat_inc32(r_perf_load);
      if (w_force_gnt) r_perf_starve <= sat_inc32(r_perf_starve);
    end
  end

  assign perf_fetch  = r_perf_fetch;
  assign perf_load   = r_perf_load;
  assign perf_starve = r_perf_starve;
`endif
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 8, consecutive loader wait cycles (1..15) before the loader is force-granted.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 f_req  in  1  fetch stage requests an imem read.
REQ-005 f_addr  in  10  fetch word address.
REQ-006 halting  in  1  pipeline halted; fetch requests are ignored while high.
REQ-007 f_gnt  out  1  fetch read issued to memory this cycle.
REQ-008 f_rvalid  out  1  f_rdata valid; registered.
REQ-009 f_rdata  out  32  read word, passed through from mem_rdata.
REQ-010 stall  out  1  f_req high and not granted this cycle.
REQ-011 ld_valid  in  1  loader write beat valid.
REQ-012 ld_addr  in  10  loader word address.
REQ-013 ld_wdata  in  32  loader write data.
REQ-014 ld_last  in  1  final beat of a burst.
REQ-015 ld_ready  out  1  beat accepted when ld_valid && ld_ready.
REQ-016 mem_en, mem_we  out  1 each  imem port enable and write enable.
REQ-017 mem_addr  out  10;  mem_wdata  out  32;  mem_rdata  in  32, synchronous read, one-cycle latency.

Function
REQ-018 FSM states: IDLE, FETCH, LOAD; state is registered and the grant is combinational from state, inputs and the counter.
REQ-019 IDLE/FETCH: if ld_valid && (halting || !f_req || starve_cnt == STARVE_MAX), grant loader and go to LOAD; otherwise, if f_req && !halting, grant fetch and go to FETCH; otherwise go to IDLE.
REQ-020 LOAD: grant the loader every cycle ld_valid is high; leave to IDLE after an accepted beat with ld_last, or after any cycle with ld_valid low.
REQ-021 Exactly one grant per cycle: f_gnt and ld_ready are never both high.
REQ-022 Fetch grant: mem_en=1, mem_we=0, mem_addr=f_addr; f_rvalid=1 on the next cycle only.
REQ-023 Loader grant: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata.
REQ-024 starve_cnt (4-bit): increments each cycle ld_valid is high and ld_ready is low; saturates at STARVE_MAX; clears on any loader grant.
REQ-025 stall = f_req && !f_gnt && !halting.
REQ-026 ld_valid dropping mid-burst ends the burst; the next ld_valid re-arbitrates from IDLE.
REQ-027 A write followed by a fetch read of the same address returns the new data, since the write completes first.

Reset
REQ-028 rst asserted: state=IDLE, starve_cnt=0, f_rvalid=0; all combinational outputs follow from IDLE with inputs, no grant is issued during reset.
REQ-029 Reset mid-burst abandons the burst; beats already written stay in memory, and no partial beat is written.

Configuration
REQ-030 Macro IMEM_ARB_PERF_EN defined: adds outputs perf_fetch (32), perf_load (32) and perf_starve (32), saturating counts of fetch grants, loader grants and force-grants; all are cleared by rst.
REQ-031 Macro IMEM_ARB_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-032 Package imem_pkg holds IMEM_AW=10, IMEM_DW=32 and the enum arb_state_t {IDLE, FETCH, LOAD}.
REQ-033 One sub-module, imem_starve_ctr, holds the saturating starvation counter and its force flag.

Verification
REQ-034 f_req=1 continuously, no loader, halting=0, addr 0,4,8 -> f_gnt=1 each cycle; f_rvalid one cycle later; mem_we=0.
REQ-035 halting=1, f_req=1, ld_valid burst of 4 beats to addr 100..103, ld_last on beat 4 -> ld_ready=1 for 4 cycles; state returns to IDLE; f_gnt stays 0 throughout.
REQ-036 f_req=1 and ld_valid=1 held, STARVE_MAX=8 -> 8 fetch grants, then a loader force-grant on the 9th cycle with stall=1 that cycle; starve_cnt returns to 0.
REQ-037 Write 0xDEADBEEF to addr 5, then fetch addr 5 the next cycle -> f_rdata=0xDEADBEEF with f_rvalid=1.
REQ-038 rst pulsed on beat 2 of a 4-beat burst -> outputs are idle immediately; mem[addr of beat 1] is written and beat 2 is not; fetch resumes after rst deasserts.
